// File: rtl/bus_array_src_pkg.sv
// Shared types and constants for the bus-array stimulus source: FSM states,
// LFSR parameters, bus widths and the driven-vector layout.
package bus_array_src_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int                LFSR_W    = 32;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] LFSR_ONE  = 32'h0000_0001;

    localparam int A_W   = 1;
    localparam int B_W   = 4;
    localparam int C_W   = 8;
    localparam int D_W   = 32;
    localparam int VEC_W = A_W + B_W + C_W + D_W;

    localparam int               IDX_W   = 16;
    localparam int               ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [C_W-1:0] c;
        logic [D_W-1:0] d;
    } vec_t;

    // Right-shifting Galois form; the mask carries taps 32, 22, 2 and 1.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_MASK : '0);
    endfunction

    function automatic vec_t vec_from_lfsr(input logic [LFSR_W-1:0] l);
        vec_t v;
        v.d = l;
        v.c = l[7:0] ^ l[15:8];
        v.b = l[3:0] ^ l[31:28];
        v.a = ^l;
        return v;
    endfunction

endpackage

// File: rtl/bus_array_src_if.sv
// Stimulus (A..D) and echo (E..H) buses between the source and the bus-array block.
interface bus_array_src_if;
    import bus_array_src_pkg::*;

    logic [A_W-1:0] A;
    logic [B_W-1:0] B;
    logic [C_W-1:0] C;
    logic [D_W-1:0] D;
    logic [A_W-1:0] E;
    logic [B_W-1:0] F;
    logic [C_W-1:0] G;
    logic [D_W-1:0] H;

    modport master (output A, B, C, D, input E, F, G, H);
    modport slave  (input A, B, C, D, output E, F, G, H);

endinterface

// File: rtl/bus_array_src_lfsr.sv
// 32-bit Galois LFSR with seed load and advance enable; a zero seed loads 1.
module bus_array_src_lfsr
    import bus_array_src_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              adv,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_d;
    logic [LFSR_W-1:0] state_q;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (seed == '0) ? LFSR_ONE : seed;
        end else if (adv) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LFSR_ONE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/bus_array_source.sv
// LFSR stimulus source and loopback checker for the registered bus-array block.
// Optional macro BUS_ARRAY_SOURCE_FIRST_FAIL_EN records the first mismatching vector index.
module bus_array_source
    import bus_array_src_pkg::*;
#(
    parameter int          NUM_VECTORS = 16,
    parameter logic [31:0] SEED        = 32'h0000_0001,
    parameter int          LAT         = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_COUNT,
    output logic [IDX_W-1:0] FAIL_INDEX,
    bus_array_src_if.master  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    state_e            state_d, state_q;
    logic [IDX_W-1:0]  idx_d, idx_q;
    vec_t              vec_d, vec_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic              pass_d, pass_q;
    logic [ERR_W-1:0]  err_d, err_q;
    logic              start_acc;
    logic              drive;
    logic [LFSR_W-1:0] lfsr_state;
    logic [LAT-1:0]    dl_vld_d, dl_vld_q;
    vec_t [LAT-1:0]    dl_vec_d, dl_vec_q;
    vec_t              echo;
    logic              mismatch;

    assign start_acc = (state_q == ST_IDLE) && START;
    assign drive     = (state_q == ST_DRIVE);

    bus_array_src_lfsr u_lfsr (
        .clk   (CLK),
        .rst_n (RST_N),
        .load  (start_acc),
        .adv   (drive),
        .seed  (SEED),
        .state (lfsr_state)
    );

    // Control: the vector index counts DRIVE cycles; DRAIN ends when the delay line is empty.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                end
            end
            ST_DRIVE: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dl_vld_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        vec_d  = drive ? vec_from_lfsr(lfsr_state) : '0;
        busy_d = drive || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // Expected-value delay line: stage LAT-1 lines up with the echo sampled on this edge.
    if (LAT == 1) begin : g_dl_single
        always_comb begin
            dl_vld_d = drive;
            dl_vec_d = vec_d;
        end
    end else begin : g_dl_shift
        always_comb begin
            dl_vld_d = {dl_vld_q[LAT-2:0], drive};
            dl_vec_d = {dl_vec_q[LAT-2:0], vec_d};
        end
    end

    always_comb begin
        echo     = {bus.E, bus.F, bus.G, bus.H};
        mismatch = dl_vld_q[LAT-1] && (echo != dl_vec_q[LAT-1]);
    end

    always_comb begin
        err_d  = err_q;
        pass_d = pass_q;
        if (start_acc) begin
            err_d  = '0;
            pass_d = 1'b0;
        end else begin
            if (mismatch && (err_q != ERR_MAX)) begin
                err_d = err_q + 1'b1;
            end
            if (state_d == ST_DONE) begin
                pass_d = (err_q == '0);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            vec_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            dl_vld_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            vec_q    <= vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            dl_vld_q <= dl_vld_d;
        end
    end

    // Payload only matters where its valid bit is set, so it carries no reset.
    always_ff @(posedge CLK) begin
        dl_vec_q <= dl_vec_d;
    end

`ifdef BUS_ARRAY_SOURCE_FIRST_FAIL_EN
    logic [LAT-1:0][IDX_W-1:0] dl_idx_d, dl_idx_q;
    logic [IDX_W-1:0]          fidx_d, fidx_q;

    if (LAT == 1) begin : g_idx_single
        always_comb begin
            dl_idx_d = idx_q;
        end
    end else begin : g_idx_shift
        always_comb begin
            dl_idx_d = {dl_idx_q[LAT-2:0], idx_q};
        end
    end

    // The first mismatch of a run is the one seen while the count is still zero.
    always_comb begin
        fidx_d = fidx_q;
        if (start_acc) begin
            fidx_d = '0;
        end else if (mismatch && (err_q == '0)) begin
            fidx_d = dl_idx_q[LAT-1];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fidx_q <= '0;
        end else begin
            fidx_q <= fidx_d;
        end
    end

    always_ff @(posedge CLK) begin
        dl_idx_q <= dl_idx_d;
    end

    assign FAIL_INDEX = fidx_q;
`else
    assign FAIL_INDEX = '0;
`endif

    assign bus.A     = vec_q.a;
    assign bus.B     = vec_q.b;
    assign bus.C     = vec_q.c;
    assign bus.D     = vec_q.d;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign ERR_COUNT = err_q;

endmodule

// File: tb/tb_bus_array_source.sv
// Randomized bench for bus_array_source: two instances (short LAT=2 run, long LAT=3 run with
// a zero seed), register loopbacks with injected faults, and a per-cycle reference model.
`timescale 1ns/1ps
module tb_bus_array_source;

    localparam int          N0 = 16;
    localparam int          L0 = 2;
    localparam logic [31:0] S0 = 32'h0000_0001;
    localparam int          N1 = 1000;
    localparam int          L1 = 3;
    localparam logic [31:0] S1 = 32'h0000_0000;
    localparam int          VW = 45;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [1:0]  busy, done, pass;
    logic [7:0]  errc0, errc1;
    logic [15:0] fidx0, fidx1;
    logic [VW-1:0] obs0, obs1;
    logic [VW-1:0] fmask [N0];
    int edge_n = 0;
    int t0 [2] = '{0, 0};
    int n_checks = 0;
    int n_pass = 0;

    bus_array_src_if bif0 ();
    bus_array_src_if bif1 ();

    bus_array_source #(.NUM_VECTORS(N0), .SEED(S0), .LAT(L0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .START(start[0]), .BUSY(busy[0]), .DONE(done[0]),
        .PASS(pass[0]), .ERR_COUNT(errc0), .FAIL_INDEX(fidx0), .bus(bif0)
    );

    bus_array_source #(.NUM_VECTORS(N1), .SEED(S1), .LAT(L1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start[1]), .BUSY(busy[1]), .DONE(done[1]),
        .PASS(pass[1]), .ERR_COUNT(errc1), .FAIL_INDEX(fidx1), .bus(bif1)
    );

    assign obs0 = {bif0.A, bif0.B, bif0.C, bif0.D};
    assign obs1 = {bif1.A, bif1.B, bif1.C, bif1.D};

    always #5 clk = ~clk;

    // One-register loopbacks; instance 0 flips the bits in fmask for the vector being echoed,
    // instance 1 has E stuck at 0.
    always @(posedge clk) begin
        int i;
        i = edge_n + 1 - t0[0] - 2;
        if (i >= 0 && i < N0)
            {bif0.E, bif0.F, bif0.G, bif0.H} <= {bif0.A, bif0.B, bif0.C, bif0.D} ^ fmask[i];
        else
            {bif0.E, bif0.F, bif0.G, bif0.H} <= {bif0.A, bif0.B, bif0.C, bif0.D};
        bif1.E <= 1'b0;
        bif1.F <= bif1.B;
        bif1.G <= bif1.C;
        bif1.H <= bif1.D;
        edge_n <= edge_n + 1;
    end

    function automatic logic [31:0] galois(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [VW-1:0] vec_of(input logic [31:0] l);
        return {^l, l[3:0] ^ l[31:28], l[7:0] ^ l[15:8], l};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One full run on instance k; every cycle of the run window is compared with the model.
    task automatic run(input int k, input bit poke);
        logic [VW-1:0] mv [$];
        logic [VW-1:0] o, ev;
        logic [31:0]   l;
        logic [7:0]    e;
        logic [15:0]   f;
        int n, lat, cnt, first;
        bit bad;
        n   = (k == 0) ? N0 : N1;
        lat = (k == 0) ? L0 : L1;
        l   = (k == 0) ? S0 : S1;
        if (l == 0) l = 32'h1;
        cnt = 0;
        first = 0;
        for (int i = 0; i < n; i++) begin
            mv.push_back(vec_of(l));
            if (k == 0) bad = (fmask[i] != '0);
            else        bad = mv[i][VW-1];
            if (bad) begin
                if (cnt == 0) first = i;
                cnt++;
            end
            l = galois(l);
        end
        @(negedge clk);
        start[k] = 1'b1;
        t0[k] = edge_n + 1;
        @(negedge clk);
        start[k] = 1'b0;
        for (int j = 0; j <= n + lat + 3; j++) begin
            @(negedge clk);
            o  = (k == 0) ? obs0 : obs1;
            ev = (j < n) ? mv[j] : '0;
            check($sformatf("cycle%0d_inst%0d", j, k), {busy[k], done[k], o},
                  {(j <= n + lat - 1), (j == n + lat), ev});
            if (k == 1 && j < n) check("d_nonzero", {63'b0, (o[31:0] != 32'h0)}, 64'd1);
            if (poke) begin
                if (j == 5) start[k] = 1'b1;
                if (j == 6) start[k] = 1'b0;
                if (j == n + lat) start[k] = 1'b1;
                if (j == n + lat + 1) start[k] = 1'b0;
            end
        end
        e = (k == 0) ? errc0 : errc1;
        f = (k == 0) ? fidx0 : fidx1;
        check("err_count", e, (cnt > 255) ? 255 : cnt);
        check("pass", pass[k], (cnt == 0));
`ifdef BUS_ARRAY_SOURCE_FIRST_FAIL_EN
        check("fail_index", f, (cnt != 0) ? first : 0);
`else
        check("fail_index", f, 0);
`endif
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N0; i++) fmask[i] = '0;
    endtask

    initial begin
        logic [63:0] m;
        int nf, fi;
        clear_faults();
        repeat (3) @(negedge clk);
        check("rst_bus0", obs0, 0);
        check("rst_bus1", obs1, 0);
        check("rst_ctl0", {busy[0], done[0], pass[0], errc0, fidx0}, 0);
        check("rst_ctl1", {busy[1], done[1], pass[1], errc1, fidx1}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 1'b0);
        fmask[5] = 45'h1;
        run(0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            clear_faults();
            nf = $urandom_range(1, 3);
            for (int q = 0; q < nf; q++) begin
                fi = $urandom_range(0, N0 - 1);
                m  = {$urandom, $urandom};
                if (m[VW-1:0] == '0) m = 64'h1;
                fmask[fi] = m[VW-1:0];
            end
            run(0, (r == 1));
        end
        clear_faults();
        run(0, 1'b1);
        run(1, 1'b0);

        // Asynchronous reset in the middle of vector 8, with two faults already counted.
        fmask[0] = 45'h1_0000_0000_00;
        fmask[1] = 45'h0_0000_0000_80;
        @(negedge clk);
        start[0] = 1'b1;
        t0[0] = edge_n + 1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("err_before_reset", errc0, 2);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_bus", obs0, 0);
        check("rst_mid_ctl", {busy[0], done[0], pass[0], errc0, fidx0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_faults();
        run(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/bus_array_source.md
# bus_array_source

Self-checking stimulus source and loopback checker for the registered bus-array test block. It drives pseudo-random vectors onto the 1/4/8/32-bit input buses (A, B, C, D) and reads the registered outputs (E, F, G, H) back. Each returned vector is compared against its expected copy after a fixed pipeline delay. It sits beside the bus-array block in prsim/VPI co-simulation benches and gives a single PASS/ERR_COUNT verdict per run.

## Interface
- NUM_VECTORS, 16, number of vectors per run (1..65535)
- SEED, 32'h0000_0001, LFSR seed loaded on START (0 is replaced by 1)
- LAT, 2, clock edges from driving a vector to sampling its echo (1..4)

- CLK  in  1  clock, all state on posedge
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low
- START  in  1  begin a run; honoured only in IDLE
- BUSY  out  1  high in DRIVE and DRAIN
- DONE  out  1  one-cycle pulse when a run completes
- PASS  out  1  valid after DONE: ERR_COUNT==0; held until next START
- ERR_COUNT  out  8  mismatching vectors, saturates at 255
- FAIL_INDEX  out  16  index of first mismatching vector (see Configuration)
- A  out  1,  B  out  4,  C  out  8,  D  out  32  stimulus buses, registered
- E  in  1,  F  in  4,  G  in  8,  H  in  32  echoed buses from the device under test

## Operation
- States: IDLE, DRIVE, DRAIN, DONE.
- IDLE -> DRIVE when START=1. On that edge:
  - LFSR <= SEED (0 replaced by 1)
  - ERR_COUNT <= 0, PASS <= 0, vector index <= 0
- Each DRIVE cycle drives vector v from LFSR state L:
  - D = L
  - C = L[7:0] ^ L[15:8]
  - B = L[3:0] ^ L[31:28]
  - A = ^L
- LFSR advances once per DRIVE cycle. It is a Galois LFSR, polynomial x^32+x^22+x^2+x+1, mask 32'h8020_0003.
- Each driven vector is pushed into a LAT-deep expected-value delay line with a valid bit.
- The valid bit emerging from the delay line enables a compare of {E,F,G,H} against the delayed vector.
  - Any bit differing counts as one mismatch.
  - ERR_COUNT increments, saturating at 255.
- DRIVE -> DRAIN after vector NUM_VECTORS-1 is driven.
- In DRAIN, A..D are driven 0 and delay-line pushes are invalid.
- DRAIN -> DONE once the last valid entry has been compared, i.e. LAT cycles after the last vector.
- DONE:
  - DONE=1 for one cycle
  - PASS <= (ERR_COUNT==0)
  - next state IDLE
- A..D are 0 in IDLE and DONE.
- START in any state other than IDLE is ignored.
- Reset mid-run returns to IDLE immediately (asynchronous). All partial results are discarded.
- Reset values:
  - state IDLE
  - A..D = 0
  - BUSY, DONE, PASS = 0
  - ERR_COUNT = 0, FAIL_INDEX = 0
  - LFSR = 1
  - delay-line valids = 0

## Timing
- START sampled at edge t: vector 0 appears on A..D after edge t+1, and BUSY=1 from edge t+1.
- Vector i is on the buses during cycle t+1+i. Its echo is sampled at edge t+1+i+LAT.
- DONE pulses in the cycle after edge t+NUM_VECTORS+LAT+1. BUSY falls on the same edge that DONE rises.
- Throughput: one vector per cycle, no bubbles.
- Minimum run: NUM_VECTORS=1 completes with DONE at t+LAT+2.
- START asserted during the DONE cycle is ignored. A new START is accepted in the following IDLE cycle.

## Configuration
- BUS_ARRAY_SOURCE_FIRST_FAIL_EN
  - Defined: FAIL_INDEX captures the vector index of the first mismatch in a run. It is cleared on START and held until the next START. The capture needs a 16-bit index field carried in the delay line.
  - Undefined: FAIL_INDEX is tied to 0, and no index field is stored in the delay line.

## Structure
- Package bus_array_src_pkg holds:
  - state enum
  - LFSR mask and width constants
  - bus widths (1/4/8/32)
  - vector struct {a,b,c,d}
- Sub-module bus_array_src_lfsr: 32-bit Galois LFSR with load, seed, advance enable and state output.
- The FSM, delay line and comparator stay in the top module.

## Test plan
- Reset, then START with SEED=1, NUM_VECTORS=16, LAT=2, and an ideal 1-register loopback model -> DONE after 19 cycles, PASS=1, ERR_COUNT=0, FAIL_INDEX=0.
- Same run with H forced to bit 0 inverted on vector 5 only -> ERR_COUNT=1, PASS=0, FAIL_INDEX=5 (with the macro defined; 0 with it undefined).
- Loopback with E stuck at 0 for 300 vectors -> ERR_COUNT saturates at 255 with no wrap.
- SEED=0 -> first D equals 32'h0000_0001; the LFSR never reaches zero across 1000 vectors.
- RST_N low in the middle of vector 8 -> outputs drop to reset values at once. A new START then yields a clean PASS.
- START pulsed while BUSY, and again during the DONE cycle -> both ignored; exactly one DONE per accepted START.
